// File: rtl/decode_pipe_pkg.sv
// Shared LEGv8 decode definitions: default widths, opcode patterns, ctrl bit
// positions and the zero-register index.
package decode_pipe_pkg;

  localparam int WORD      = 64;
  localparam int INSTR_LEN = 32;
  localparam int NREGS     = 32;
  localparam int XZR       = NREGS - 1;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  // ctrl = {alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch,
  //         uncond_branch, alu_op[1:0]}; reg2loc only steers read port 2.
  localparam int CTRL_W          = 9;
  localparam int CTRL_ALU_OP_LO  = 0;
  localparam int CTRL_ALU_OP_HI  = 1;
  localparam int CTRL_UNCOND     = 2;
  localparam int CTRL_BRANCH     = 3;
  localparam int CTRL_MEM_WRITE  = 4;
  localparam int CTRL_MEM_READ   = 5;
  localparam int CTRL_REG_WRITE  = 6;
  localparam int CTRL_MEM_TO_REG = 7;
  localparam int CTRL_ALU_SRC    = 8;

  function automatic int zero_reg(input int nregs);
    return nregs - 1;
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// Register file: two combinational read ports, one synchronous write port,
// hard-wired zero register and optional write-back bypass.
module decode_regfile #(
  parameter int WORD   = decode_pipe_pkg::WORD,
  parameter int NREGS  = decode_pipe_pkg::NREGS,
  parameter int BYPASS = 1,
  localparam int RADDR = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RADDR-1:0] raddr1,
  input  logic [RADDR-1:0] raddr2,
  output logic [WORD-1:0]  rdata1,
  output logic [WORD-1:0]  rdata2,
  input  logic             wb_en,
  input  logic [RADDR-1:0] wb_reg,
  input  logic [WORD-1:0]  wb_data
);
  import decode_pipe_pkg::*;

  localparam logic [RADDR-1:0] ZR = RADDR'(zero_reg(NREGS));

  logic [WORD-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en && wb_reg != ZR) begin
      regs[wb_reg] <= wb_data;
    end
  end

  always_comb begin
    rdata1 = regs[raddr1];
    if (raddr1 == ZR) rdata1 = '0;
    else if (BYPASS != 0 && wb_en && raddr1 == wb_reg) rdata1 = wb_data;
  end

  always_comb begin
    rdata2 = regs[raddr2];
    if (raddr2 == ZR) rdata2 = '0;
    else if (BYPASS != 0 && wb_en && raddr2 == wb_reg) rdata2 = wb_data;
  end

endmodule

// File: rtl/decode_pipe.sv
// LEGv8 decode stage: field/control decode, load-use stall, and a single
// registered output slot feeding EX.
module decode_pipe #(
  parameter int WORD   = decode_pipe_pkg::WORD,
  parameter int NREGS  = decode_pipe_pkg::NREGS,
  parameter int BYPASS = 1,
  localparam int RADDR = $clog2(NREGS)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [decode_pipe_pkg::INSTR_LEN-1:0] instruction,
  input  logic [WORD-1:0]                       pc_in,
  input  logic                                  flush,
  input  logic                                  ex_mem_read,
  input  logic [RADDR-1:0]                      ex_rd,
  input  logic                                  wb_en,
  input  logic [RADDR-1:0]                      wb_reg,
  input  logic [WORD-1:0]                       wb_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [10:0]                           opcode,
  output logic [RADDR-1:0]                      rd,
  output logic [WORD-1:0]                       read_data1,
  output logic [WORD-1:0]                       read_data2,
  output logic [WORD-1:0]                       imm,
  output logic [WORD-1:0]                       pc_out,
  output logic [decode_pipe_pkg::CTRL_W-1:0]    ctrl
);
  import decode_pipe_pkg::*;

  localparam logic [RADDR-1:0] ZR = RADDR'(zero_reg(NREGS));

  logic [10:0]       op;
  logic              reg2loc;
  logic [CTRL_W-1:0] ctrl_d;
  logic [WORD-1:0]   imm_d;
  logic [RADDR-1:0]  ra1, ra2;
  logic [WORD-1:0]   rf_data1, rf_data2;
  logic              hazard, slot_free;
  logic              unused_shamt;

  assign op           = instruction[31:21];
  assign unused_shamt = ^instruction[11:10];

  always_comb begin
    ctrl_d  = '0;
    imm_d   = '0;
    reg2loc = 1'b0;
    if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) begin
      ctrl_d[CTRL_REG_WRITE] = 1'b1;
      ctrl_d[CTRL_ALU_OP_HI] = 1'b1;
    end else if (op == OP_LDUR) begin
      ctrl_d[CTRL_ALU_SRC]    = 1'b1;
      ctrl_d[CTRL_MEM_READ]   = 1'b1;
      ctrl_d[CTRL_MEM_TO_REG] = 1'b1;
      ctrl_d[CTRL_REG_WRITE]  = 1'b1;
      imm_d = {{(WORD-9){instruction[20]}}, instruction[20:12]};
    end else if (op == OP_STUR) begin
      reg2loc                = 1'b1;
      ctrl_d[CTRL_ALU_SRC]   = 1'b1;
      ctrl_d[CTRL_MEM_WRITE] = 1'b1;
      imm_d = {{(WORD-9){instruction[20]}}, instruction[20:12]};
    end else if (instruction[31:24] == OP_CBZ) begin
      reg2loc                = 1'b1;
      ctrl_d[CTRL_BRANCH]    = 1'b1;
      ctrl_d[CTRL_ALU_OP_LO] = 1'b1;
      imm_d = {{(WORD-19){instruction[23]}}, instruction[23:5]};
    end else if (instruction[31:26] == OP_B) begin
      ctrl_d[CTRL_UNCOND] = 1'b1;
      imm_d = {{(WORD-26){instruction[25]}}, instruction[25:0]};
    end
  end

  assign ra1 = instruction[5 +: RADDR];
  assign ra2 = reg2loc ? instruction[0 +: RADDR] : instruction[16 +: RADDR];

  decode_regfile #(.WORD(WORD), .NREGS(NREGS), .BYPASS(BYPASS)) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .raddr1  (ra1),
    .raddr2  (ra2),
    .rdata1  (rf_data1),
    .rdata2  (rf_data2),
    .wb_en   (wb_en),
    .wb_reg  (wb_reg),
    .wb_data (wb_data)
  );

  // Handshake: a transfer happens on an edge where valid && ready; a held
  // bundle never changes while out_valid && !out_ready; in_ready may depend
  // combinationally on in_valid/instruction through the load-use check.
  assign hazard    = in_valid && ex_mem_read && ex_rd != ZR && (ex_rd == ra1 || ex_rd == ra2);
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = slot_free && !hazard;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      ctrl       <= '0;
      opcode     <= '0;
      rd         <= '0;
      imm        <= '0;
      read_data1 <= '0;
      read_data2 <= '0;
      pc_out     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid  <= 1'b1;
      ctrl       <= ctrl_d;
      opcode     <= op;
      rd         <= instruction[0 +: RADDR];
      imm        <= imm_d;
      read_data1 <= rf_data1;
      read_data2 <= rf_data2;
      pc_out     <= pc_in;
    end else if (hazard && slot_free) begin
      // Stalled behind a load: hand EX an all-zero bubble instead of a gap.
      out_valid  <= 1'b1;
      ctrl       <= '0;
      opcode     <= '0;
      rd         <= '0;
      imm        <= '0;
      read_data1 <= '0;
      read_data2 <= '0;
      pc_out     <= '0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: directed scenarios plus random traffic, checked by a
// queue scoreboard fed from an instruction-level reference model.
module tb_decode_pipe;

  localparam int W  = 64;
  localparam int BW = 11 + 5 + 4 * W + 9;

  localparam logic [10:0] ADD_OP  = 11'b10001011000;
  localparam logic [10:0] SUB_OP  = 11'b11001011000;
  localparam logic [10:0] AND_OP  = 11'b10001010000;
  localparam logic [10:0] ORR_OP  = 11'b10101010000;
  localparam logic [10:0] LDUR_OP = 11'b11111000010;
  localparam logic [10:0] STUR_OP = 11'b11111000000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, flush, ex_mem_read, wb_en, out_valid, out_ready;
  logic [31:0]   instruction;
  logic [W-1:0]  pc_in, wb_data, read_data1, read_data2, imm, pc_out;
  logic [4:0]    ex_rd, wb_reg, rd;
  logic [10:0]   opcode;
  logic [8:0]    ctrl;

  decode_pipe #(.WORD(W), .NREGS(32), .BYPASS(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instruction (instruction),
    .pc_in       (pc_in),
    .flush       (flush),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .wb_en       (wb_en),
    .wb_reg      (wb_reg),
    .wb_data     (wb_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .opcode      (opcode),
    .rd          (rd),
    .read_data1  (read_data1),
    .read_data2  (read_data2),
    .imm         (imm),
    .pc_out      (pc_out),
    .ctrl        (ctrl)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0]  ref_regs [32];
  logic [BW-1:0] exp_q [$];
  bit            model_full;

  function automatic logic [W-1:0] ref_read(input logic [4:0] a);
    if (a == 5'd31) return '0;
    if (wb_en && wb_reg == a) return wb_data;
    return ref_regs[a];
  endfunction

  function automatic bit reads_rt(input logic [31:0] ins);
    return ins[31:21] == STUR_OP || ins[31:24] == 8'b10110100;
  endfunction

  function automatic logic [BW-1:0] ref_bundle(input logic [31:0] ins, input logic [W-1:0] pc);
    logic [10:0]  op;
    logic [8:0]   c;
    logic [W-1:0] iv;
    logic [4:0]   r2;
    op = ins[31:21];
    c  = '0;
    iv = '0;
    if (op inside {ADD_OP, SUB_OP, AND_OP, ORR_OP}) c = 9'b0_0_1_0_0_0_0_10;
    else if (op == LDUR_OP) begin
      c  = 9'b1_1_1_1_0_0_0_00;
      iv = {{55{ins[20]}}, ins[20:12]};
    end else if (op == STUR_OP) begin
      c  = 9'b1_0_0_0_1_0_0_00;
      iv = {{55{ins[20]}}, ins[20:12]};
    end else if (ins[31:24] == 8'b10110100) begin
      c  = 9'b0_0_0_0_0_1_0_01;
      iv = {{45{ins[23]}}, ins[23:5]};
    end else if (ins[31:26] == 6'b000101) begin
      c  = 9'b0_0_0_0_0_0_1_00;
      iv = {{38{ins[25]}}, ins[25:0]};
    end
    r2 = reads_rt(ins) ? ins[4:0] : ins[20:16];
    return {op, ins[4:0], ref_read(ins[9:5]), ref_read(r2), iv, pc, c};
  endfunction

  always @(posedge clk) begin
    bit stall, free, exp_ready;
    logic [4:0] ra2;
    if (reset) begin
      exp_q.delete();
      model_full = 1'b0;
      foreach (ref_regs[i]) ref_regs[i] = '0;
    end else begin
      ra2       = reads_rt(instruction) ? instruction[4:0] : instruction[20:16];
      stall     = in_valid && ex_mem_read && ex_rd != 5'd31 &&
                  (ex_rd == instruction[9:5] || ex_rd == ra2);
      free      = !model_full || out_ready;
      exp_ready = free && !stall;
      chk("in_ready", in_ready, exp_ready);
      chk("out_valid", out_valid, model_full);
      if (flush) begin
        if (model_full && !out_ready) void'(exp_q.pop_front());
        model_full = 1'b0;
      end else if (in_valid && exp_ready) begin
        exp_q.push_back(ref_bundle(instruction, pc_in));
        model_full = 1'b1;
      end else if (stall && free) begin
        exp_q.push_back('0);
        model_full = 1'b1;
      end else if (out_ready) begin
        model_full = 1'b0;
      end
      if (wb_en && wb_reg != 5'd31) ref_regs[wb_reg] = wb_data;
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin
    logic [BW-1:0] act, exp;
    if (!reset && out_valid && out_ready) begin
      act = {opcode, rd, read_data1, read_data2, imm, pc_out, ctrl};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL bundle_unexpected: got %0h expected nothing", act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          bad++;
          $display("FAIL bundle: got %0h expected %0h", act, exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rm,
                                        input logic [4:0] rn, input logic [4:0] rdst);
    return {op, rm, 6'd0, rn, rdst};
  endfunction

  function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [8:0] off,
                                        input logic [4:0] rn, input logic [4:0] rt);
    return {op, off, 2'b00, rn, rt};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] a, b, c;
    a = 5'($urandom_range(0, 31));
    b = 5'($urandom_range(0, 31));
    c = 5'($urandom_range(0, 31));
    case ($urandom_range(0, 8))
      0: return enc_r(ADD_OP, a, b, c);
      1: return enc_r(SUB_OP, a, b, c);
      2: return enc_r(AND_OP, a, b, c);
      3: return enc_r(ORR_OP, a, b, c);
      4: return enc_d(LDUR_OP, 9'($urandom), b, c);
      5: return enc_d(STUR_OP, 9'($urandom), b, c);
      6: return {8'b10110100, 19'($urandom), c};
      7: return {6'b000101, 26'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  task automatic idle_inputs();
    in_valid = 1'b0; flush = 1'b0; ex_mem_read = 1'b0; ex_rd = '0;
    wb_en = 1'b0; wb_reg = '0; wb_data = '0; out_ready = 1'b1;
    instruction = '0; pc_in = '0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic offer(input logic [31:0] ins, input logic [W-1:0] pc);
    in_valid = 1'b1; instruction = ins; pc_in = pc;
  endtask

  task automatic write_back(input logic [4:0] r, input logic [W-1:0] d);
    wb_en = 1'b1; wb_reg = r; wb_data = d;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_ctrl"}, ctrl, 0);
    chk({tag, "_opcode"}, opcode, 0);
    chk({tag, "_rd"}, rd, 0);
    chk({tag, "_imm"}, imm, 0);
    chk({tag, "_read_data1"}, read_data1, 0);
    chk({tag, "_read_data2"}, read_data2, 0);
    chk({tag, "_pc_out"}, pc_out, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    idle_inputs();
    repeat (2) tick();
    check_all_zero("reset");
    reset = 1'b0;
    #1 chk("in_ready_after_reset", in_ready, 1);
    tick();

    // Load after a register write: LDUR X2, [X1, #8]
    write_back(5'd1, 64'd5);
    tick();
    wb_en = 1'b0;
    offer(enc_d(LDUR_OP, 9'd8, 5'd1, 5'd2), 64'h100);
    tick();
    in_valid = 1'b0;
    chk("ldur_out_valid", out_valid, 1);
    chk("ldur_opcode", opcode, LDUR_OP);
    chk("ldur_read_data1", read_data1, 5);
    chk("ldur_imm", imm, 8);
    chk("ldur_mem_read", ctrl[5], 1);

    // Same-cycle write-back bypass: ADD X4, X3, X3 while X3 <- 0xAA
    write_back(5'd3, 64'hAA);
    offer(enc_r(ADD_OP, 5'd3, 5'd3, 5'd4), 64'h104);
    tick();
    wb_en = 1'b0;
    in_valid = 1'b0;
    chk("bypass_read_data1", read_data1, 64'hAA);
    chk("bypass_read_data2", read_data2, 64'hAA);

    // Load-use stall: SUB X5, X2, X6 behind a load to X2
    ex_mem_read = 1'b1;
    ex_rd = 5'd2;
    offer(enc_r(SUB_OP, 5'd6, 5'd2, 5'd5), 64'h108);
    #1 chk("stall_in_ready", in_ready, 0);
    tick();
    chk("bubble_out_valid", out_valid, 1);
    chk("bubble_ctrl", ctrl, 0);
    ex_mem_read = 1'b0;
    #1 chk("unstall_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("sub_opcode", opcode, SUB_OP);
    chk("sub_ctrl", ctrl, 9'b001000010);

    // Back-pressure for three cycles, then flush
    out_ready = 1'b0;
    offer(enc_r(ORR_OP, 5'd1, 5'd1, 5'd9), 64'h10C);
    for (int i = 0; i < 3; i++) begin
      #1 chk("hold_in_ready", in_ready, 0);
      tick();
      chk("hold_out_valid", out_valid, 1);
      chk("hold_opcode", opcode, SUB_OP);
      chk("hold_pc_out", pc_out, 64'h108);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    out_ready = 1'b1;

    // XZR write is dropped: CBZ XZR, #-4
    write_back(5'd31, 64'hFF);
    tick();
    wb_en = 1'b0;
    offer({8'b10110100, 19'h7FFFC, 5'd31}, 64'h200);
    tick();
    in_valid = 1'b0;
    chk("cbz_read_data2", read_data2, 0);
    chk("cbz_imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("cbz_branch", ctrl[3], 1);
    tick();

    // Random traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      in_valid    = $urandom_range(0, 3) != 0;
      instruction = rand_instr();
      pc_in       = {$urandom, $urandom};
      wb_en       = 1'($urandom_range(0, 1));
      wb_reg      = 5'($urandom_range(0, 31));
      wb_data     = {$urandom, $urandom};
      ex_mem_read = $urandom_range(0, 4) == 0;
      ex_rd       = $urandom_range(0, 1) != 0 ? instruction[9:5] : 5'($urandom_range(0, 31));
      out_ready   = $urandom_range(0, 4) != 0;
      flush       = $urandom_range(0, 19) == 0;
      tick();
    end

    // Reset mid-stream with a write-back and an offer in flight
    idle_inputs();
    write_back(5'd1, 64'h77);
    offer(enc_r(ADD_OP, 5'd3, 5'd1, 5'd7), 64'h300);
    ex_mem_read = 1'b1;
    ex_rd = 5'd1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_inputs();
    check_all_zero("midreset");
    #1 chk("in_ready_after_midreset", in_ready, 1);
    offer(enc_r(ADD_OP, 5'd3, 5'd1, 5'd7), 64'h304);
    tick();
    in_valid = 1'b0;
    chk("midreset_x1", read_data1, 0);
    chk("midreset_x3", read_data2, 0);

    repeat (4) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 The module SHALL take parameter WORD, default 64, as the datapath width in bits.
REQ-002 The module SHALL take parameter NREGS, default 32, as the register count; RADDR = clog2(NREGS), and register NREGS-1 is the zero register XZR.
REQ-003 The module SHALL take parameter BYPASS, default 1; when 1, a same-cycle write-back is visible to decode reads.
REQ-004 Ports SHALL be as follows; there is one clock, and reset is synchronous and active-high:
 - clk  in  1  sole clock, rising edge
 - reset  in  1  synchronous, active-high
 - in_valid  in  1  fetch offers an instruction
 - in_ready  out  1  decode accepts this cycle
 - instruction  in  32  LEGv8 instruction word
 - pc_in  in  WORD  PC of the instruction
 - flush  in  1  branch-taken kill
 - ex_mem_read  in  1  EX-stage instruction is a load
 - ex_rd  in  RADDR  EX-stage destination register
 - wb_en  in  1  write-back enable
 - wb_reg  in  RADDR  write-back register
 - wb_data  in  WORD  write-back value
 - out_valid  out  1  decoded bundle valid
 - out_ready  in  1  EX accepts the bundle
 - opcode  out  11  instruction[31:21]
 - rd  out  RADDR  instruction[4:0]
 - read_data1, read_data2  out  WORD  operand values
 - imm  out  WORD  sign-extended immediate
 - pc_out  out  WORD  registered PC
 - ctrl  out  9  {reg2loc, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, uncond_branch, alu_op[1:0]} minus reg2loc, i.e. 9 bits (alu_src..alu_op).

Function
REQ-005 The output stage SHALL be a single registered slot: the bundle loads on in_valid && in_ready, and in_ready = !out_valid || out_ready, gated by REQ-009.
REQ-006 The stage SHALL have a latency of exactly 1 cycle from acceptance to out_valid, and the bundle SHALL hold stable while out_valid && !out_ready.
REQ-007 Decode SHALL map opcodes as follows; all other opcodes decode as a NOP bubble with all ctrl bits 0 while still asserting out_valid:
 - R-type ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000: reg_write=1, alu_op=10.
 - LDUR 11111000010: alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1, alu_op=00.
 - STUR 11111000000: reg2loc=1, alu_src=1, mem_write=1, alu_op=00.
 - CBZ [31:24]=10110100: reg2loc=1, branch=1, alu_op=01.
 - B [31:26]=000101: uncond_branch=1.
REQ-008 Read port 2 SHALL address instruction[4:0] when reg2loc=1 and instruction[20:16] otherwise; read port 1 SHALL always address instruction[9:5].
REQ-009 A load-use stall SHALL force in_ready=0 when ex_mem_read=1, ex_rd!=XZR, and ex_rd equals read port 1 or read port 2 of the offered instruction; during the stall the slot is loaded with a bubble (out_valid=1, ctrl=0) if EX consumes the current bundle.
REQ-010 The immediate SHALL be formed as follows, sign-extended to WORD: D-type from instruction[20:12], CB from [23:5], B from [25:0], and 0 for R-type and NOP.
REQ-011 Register writes SHALL occur on the clk edge when wb_en=1 and wb_reg!=XZR; writes to XZR are dropped, and reads of XZR return 0.
REQ-012 When BYPASS=1, a read whose address equals wb_reg while wb_en=1 SHALL return wb_data in the same cycle; when BYPASS=0 it SHALL return the old value.
REQ-013 flush=1 SHALL clear out_valid on the next edge and SHALL discard any instruction offered in that cycle; flush takes priority over accept and stall, while a write-back in the same cycle still commits.
REQ-014 Operand values SHALL be captured in the slot at acceptance and are not refreshed by later write-backs.

Reset
REQ-015 While reset=1 at an edge, out_valid, ctrl, opcode, rd, imm, read_data1, read_data2 and pc_out SHALL all be set to 0.
REQ-016 The register file SHALL clear to 0 on reset; a write-back in the reset cycle is ignored.
REQ-017 In the cycle after reset deasserts, in_ready SHALL be 1, and a reset mid-stall SHALL abandon the stall.

Structure
REQ-018 The opcode constants, the ctrl bit-index localparams and the XZR index SHALL live in the shared definitions header alongside WORD and INSTR_LEN.
REQ-019 The register file SHALL be one sub-module, decode_regfile, parametrised by WORD, NREGS and BYPASS, with 2 combinational read ports and 1 synchronous write port; decode and hazard logic remain in decode_pipe.

Verification
REQ-020 The bench SHALL cover: write X1=5 then LDUR X2,[X1,#8] -> one cycle later opcode=11111000010, read_data1=5, imm=8, mem_read=1.
REQ-021 The bench SHALL cover: wb X3=0xAA in the same cycle as decoding ADD X4,X3,X3 with BYPASS=1 -> read_data1=read_data2=0xAA.
REQ-022 The bench SHALL cover: ex_mem_read=1, ex_rd=2 with SUB X5,X2,X6 offered -> in_ready=0 for that cycle and a bubble is emitted (ctrl=0); accepted next cycle once ex_mem_read=0.
REQ-023 The bench SHALL cover: out_ready=0 for 3 cycles -> bundle unchanged and in_ready=0; then flush=1 -> out_valid=0 next cycle.
REQ-024 The bench SHALL cover: wb to XZR with 0xFF then CBZ XZR,#-4 -> read_data2=0, imm=all-ones...FFFC, branch=1.
REQ-025 The bench SHALL cover: reset asserted mid-stream -> all outputs 0 and registers 0 on the next edge.
